// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one buart transmitter between NREQ byte-stream requesters.
//   Round-robin selection with packet lock: the granted requester keeps the
//   transmitter until it hands over a byte flagged last. Each accepted byte
//   is written to the buart and the next issue waits for buart busy to drop.
//
//   Optional build macro: UART_ARB_STOP_GUARD_EN
//     defined   - after busy falls, hold off GUARD_CYCLES clocks so the stop
//                 bit runs full length before the next start bit
//     undefined - return to selection as soon as busy falls
//
// Parameters
//   NREQ          number of requesters (2..8)
//   GUARD_CYCLES  stop-bit hold-off in clk cycles (guard build only)
// Ports
//   clk        system clock
//   resetq     asynchronous active-low reset
//   req_valid  requester i presents a byte on req_data[8*i+:8]
//   req_data   packed requester bytes
//   req_last   byte of requester i ends its packet
//   req_ready  byte of requester i accepted this cycle
//   grant      one-hot current owner, 0 while unlocked in selection
//   tx_wr      buart write strobe
//   tx_data    buart byte
//   tx_busy    buart busy

module uart_tx_arbiter #(
   parameter int NREQ         = 2,
   parameter int GUARD_CYCLES = 104
) (
   input  logic              clk,
   input  logic              resetq,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   grant,
   output logic              tx_wr,
   output logic [7:0]        tx_data,
   input  logic              tx_busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 2 || NREQ > 8 || GUARD_CYCLES < 1) begin : g_bad_param
      $error("uart_tx_arbiter: NREQ must be 2..8 and GUARD_CYCLES >= 1");
   end

   typedef enum logic [2:0] {
      SEL,
      ISSUE,
      WSTART,
`ifdef UART_ARB_STOP_GUARD_EN
      WDONE,
      GUARD
`else
      WDONE
`endif
   } state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   ptr;
   logic            lock;

   logic            pick_found;
   logic [IW-1:0]   pick_idx;
   logic [IW:0]     cand;
   logic            owner_valid;
   logic            owner_last;
   logic [7:0]      owner_byte;
   logic [NREQ-1:0] owner_hot;

`ifdef UART_ARB_STOP_GUARD_EN
   localparam int CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   logic [CW-1:0]   guard_cnt;
`endif

   // Round-robin scan starting at ptr; wrap is done by compare so that
   // non-power-of-two NREQ never selects a nonexistent requester.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr} + (IW+1)'(k);
         if (cand >= (IW+1)'(NREQ))
            cand = cand - (IW+1)'(NREQ);
         if (!pick_found && req_valid[cand[IW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      owner_valid = 1'b0;
      owner_last  = 1'b0;
      owner_byte  = '0;
      owner_hot   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (owner == IW'(k)) begin
            owner_valid  = req_valid[k];
            owner_last   = req_last[k];
            owner_byte   = req_data[8*k +: 8];
            owner_hot[k] = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) state <= SEL;
      else         state <= state_nxt;
   end

   // Next-state logic. SEL never leaves while busy is high, which also
   // protects a frame still in flight after a reset of this block alone.
   always_comb begin
      state_nxt = state;
      case (state)
         SEL: begin
            if (!tx_busy) begin
               if (lock) begin
                  if (owner_valid) state_nxt = ISSUE;
               end else if (pick_found) begin
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE:  state_nxt = WSTART;
         WSTART: state_nxt = WDONE;
         WDONE: begin
`ifdef UART_ARB_STOP_GUARD_EN
            if (!tx_busy) state_nxt = GUARD;
`else
            if (!tx_busy) state_nxt = SEL;
`endif
         end
`ifdef UART_ARB_STOP_GUARD_EN
         GUARD: if (guard_cnt == '0) state_nxt = SEL;
`endif
         default: state_nxt = SEL;
      endcase
   end

   // Owner, lock and round-robin pointer; pointer moves only on release.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         owner <= '0;
         lock  <= 1'b0;
         ptr   <= '0;
      end else begin
         if (state == SEL && !tx_busy && !lock && pick_found) begin
            owner <= pick_idx;
            lock  <= 1'b1;
         end
         if (state == ISSUE && owner_last) begin
            lock <= 1'b0;
            ptr  <= (owner == IW'(NREQ-1)) ? '0 : owner + IW'(1);
         end
      end
   end

`ifdef UART_ARB_STOP_GUARD_EN
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq)
         guard_cnt <= '0;
      else if (state == WDONE && !tx_busy)
         guard_cnt <= CW'(GUARD_CYCLES - 1);
      else if (state == GUARD && guard_cnt != '0)
         guard_cnt <= guard_cnt - CW'(1);
   end
`endif

   // Outputs
   always_comb begin
      req_ready = '0;
      tx_wr     = 1'b0;
      tx_data   = '0;
      grant     = (lock || state != SEL) ? owner_hot : '0;
      if (state == ISSUE) begin
         tx_wr     = 1'b1;
         tx_data   = owner_byte;
         req_ready = owner_hot;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Bench for uart_tx_arbiter with NREQ=2, GUARD_CYCLES=4 and a behavioural
//   buart stand-in (busy rises one clk after wr, lasts FRAME clks, not reset).
//   Expected byte order comes from a packet-level round-robin model.

module tb_uart_tx_arbiter;

   localparam int NREQ  = 2;
   localparam int GUARD = 4;
   localparam int FRAME = 20;
`ifdef UART_ARB_STOP_GUARD_EN
   localparam int GEXTRA = GUARD;
`else
   localparam int GEXTRA = 0;
`endif

   logic              clk = 1'b0;
   logic              resetq;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   grant;
   logic              tx_wr;
   logic [7:0]        tx_data;
   logic              tx_busy;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(NREQ), .GUARD_CYCLES(GUARD)) dut (
      .clk(clk), .resetq(resetq), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .grant(grant),
      .tx_wr(tx_wr), .tx_data(tx_data), .tx_busy(tx_busy)
   );

   // buart stand-in
   int unsigned bcnt = 0;
   int          overruns = 0;
   logic [7:0]  sent_q[$];
   assign tx_busy = (bcnt != 0);
   always @(posedge clk) begin
      if (tx_wr) begin
         if (bcnt != 0) overruns <= overruns + 1;
         bcnt <= FRAME;
         sent_q.push_back(tx_data);
      end else if (bcnt != 0) begin
         bcnt <= bcnt - 1;
      end
   end

   // Packet model state: pq[i] holds {last,byte} entries still to send
   logic [8:0] pq[NREQ][$];
   int         model_ptr = 0;
   logic [7:0] exp_byte[$];
   int         exp_owner[$];

   // Observations from the traffic engine
   logic [7:0]      obs_txd[$];
   int              obs_req[$];
   logic [NREQ-1:0] obs_grant[$];
   int multi_ready, idle_min, idle_max, spacing_min, sent_base;
   bit timed_out;
   int hold[NREQ];

   function automatic void build_expected();
      logic [8:0] w[NREQ][$];
      logic [8:0] e;
      int found;
      exp_byte.delete();
      exp_owner.delete();
      for (int i = 0; i < NREQ; i++) w[i] = pq[i];
      forever begin
         found = -1;
         for (int k = 0; k < NREQ; k++)
            if (found < 0 && w[(model_ptr + k) % NREQ].size() > 0)
               found = (model_ptr + k) % NREQ;
         if (found < 0) break;
         do begin
            e = w[found].pop_front();
            exp_byte.push_back(e[7:0]);
            exp_owner.push_back(found);
         end while (!e[8]);
         model_ptr = (found + 1) % NREQ;
      end
   endfunction

   task automatic drive_reqs();
      for (int i = 0; i < NREQ; i++) begin
         if (pq[i].size() > 0 && hold[i] == 0) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = pq[i][0][7:0];
            req_last[i]        = pq[i][0][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
         if (hold[i] > 0) hold[i]--;
      end
   endtask

   // Plays pq through the DUT; non-last bytes are followed by a pause of
   // hold_min..hold_max cycles. Records what it sees, compares nothing.
   task automatic run_traffic(input int hold_min, input int hold_max, input int max_cycles);
      int cyc, acc, nr, last_wr, fall, gap;
      bit prev_busy, all_empty;
      logic [8:0] e;
      obs_txd.delete(); obs_req.delete(); obs_grant.delete();
      multi_ready = 0; idle_min = 1 << 30; idle_max = -1; spacing_min = 1 << 30;
      timed_out = 0; sent_base = sent_q.size();
      cyc = 0; last_wr = -1; fall = -1; prev_busy = tx_busy;
      for (int i = 0; i < NREQ; i++) hold[i] = 0;
      build_expected();
      drive_reqs();
      forever begin
         @(negedge clk);
         acc = -1; nr = 0;
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin nr++; acc = i; end
         if (nr > 1) multi_ready++;
         if (prev_busy && !tx_busy) fall = cyc;
         prev_busy = tx_busy;
         if (tx_wr) begin
            if (last_wr >= 0 && cyc - last_wr < spacing_min) spacing_min = cyc - last_wr;
            if (fall >= 0) begin
               gap = cyc - fall - 1;
               if (gap < idle_min) idle_min = gap;
               if (gap > idle_max) idle_max = gap;
            end
            last_wr = cyc; fall = -1;
         end
         if (acc >= 0) begin
            obs_txd.push_back(tx_data);
            obs_req.push_back(acc);
            obs_grant.push_back(grant);
         end
         @(posedge clk); #1;
         if (acc >= 0 && pq[acc].size() > 0) begin
            e = pq[acc].pop_front();
            if (!e[8]) hold[acc] = $urandom_range(hold_max, hold_min);
         end
         drive_reqs();
         cyc++;
         all_empty = 1'b1;
         for (int i = 0; i < NREQ; i++) if (pq[i].size() > 0) all_empty = 1'b0;
         if (all_empty && bcnt == 0) break;
         if (cyc > max_cycles) begin timed_out = 1; break; end
      end
      req_valid = '0;
      repeat (GEXTRA + 3) @(posedge clk);
      #1;
   endtask

   // Common comparison of engine observations against the model
   task automatic check_traffic(input string tag, input bit exact_gap);
      total++;
      if (timed_out !== 1'b0) $display("FAIL %s timeout: cycle budget exhausted", tag);
      else passed++;
      total++;
      if (obs_txd.size() != exp_byte.size())
         $display("FAIL %s count: got %0d bytes, expected %0d", tag, obs_txd.size(), exp_byte.size());
      else passed++;
      for (int k = 0; k < exp_byte.size() && k < obs_txd.size(); k++) begin
         total++;
         if (obs_txd[k] !== exp_byte[k] || obs_req[k] != exp_owner[k])
            $display("FAIL %s order[%0d]: got req%0d 0x%02h, expected req%0d 0x%02h",
                     tag, k, obs_req[k], obs_txd[k], exp_owner[k], exp_byte[k]);
         else passed++;
         total++;
         if (obs_grant[k] !== NREQ'(1 << exp_owner[k]))
            $display("FAIL %s grant[%0d]: got %b, expected %b", tag, k, obs_grant[k], NREQ'(1 << exp_owner[k]));
         else passed++;
      end
      for (int k = 0; k < exp_byte.size(); k++) begin
         total++;
         if (sent_base + k >= sent_q.size())
            $display("FAIL %s txd[%0d]: no frame, expected 0x%02h", tag, k, exp_byte[k]);
         else if (sent_q[sent_base + k] !== exp_byte[k])
            $display("FAIL %s txd[%0d]: got 0x%02h, expected 0x%02h", tag, k, sent_q[sent_base + k], exp_byte[k]);
         else passed++;
      end
      total++;
      if (multi_ready != 0) $display("FAIL %s ready_onehot: %0d cycles with several ready", tag, multi_ready);
      else passed++;
      total++;
      if (exp_byte.size() > 1 && spacing_min < FRAME + 3 + GEXTRA)
         $display("FAIL %s spacing: got %0d, minimum %0d", tag, spacing_min, FRAME + 3 + GEXTRA);
      else passed++;
      if (exact_gap) begin
         total++;
         if (idle_min != 1 + GEXTRA || idle_max != 1 + GEXTRA)
            $display("FAIL %s idle_gap: got %0d..%0d, expected %0d", tag, idle_min, idle_max, 1 + GEXTRA);
         else passed++;
      end
      total++;
      if (grant !== '0 || tx_wr !== 1'b0)
         $display("FAIL %s idle_grant: got grant=%b tx_wr=%b, expected 0/0", tag, grant, tx_wr);
      else passed++;
      total++;
      if (overruns != 0) $display("FAIL %s overrun: got %0d writes while busy, expected 0", tag, overruns);
      else passed++;
   endtask

   task automatic test_reset();
      resetq = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
      #1;
      total++;
      if (grant !== '0 || tx_wr !== 1'b0 || req_ready !== '0 || tx_data !== 8'h00)
         $display("FAIL reset_outputs: got g=%b wr=%b rdy=%b d=%02h, expected zeros", grant, tx_wr, req_ready, tx_data);
      else passed++;
      repeat (3) @(posedge clk);
      #2 resetq = 1'b1;
      model_ptr = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         total++;
         if (grant !== '0 || tx_wr !== 1'b0 || req_ready !== '0)
            $display("FAIL reset_idle: cycle %0d got g=%b wr=%b rdy=%b, expected 0", c, grant, tx_wr, req_ready);
         else passed++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_lock_priority();
      pq[0].push_back({1'b0, 8'h41});
      pq[0].push_back({1'b1, 8'h42});
      pq[1].push_back({1'b1, 8'h55});
      run_traffic(0, 0, 400);
      check_traffic("lock_priority", 1'b1);
   endtask

   task automatic test_round_robin();
      for (int n = 0; n < 4; n++)
         for (int i = 0; i < NREQ; i++)
            pq[i].push_back({1'b1, 8'($urandom_range(255))});
      run_traffic(0, 0, 800);
      check_traffic("round_robin", 1'b1);
      for (int k = 1; k < obs_req.size(); k++) begin
         total++;
         if (obs_req[k] == obs_req[k-1])
            $display("FAIL rr_alternate[%0d]: got req%0d twice, expected alternation", k, obs_req[k]);
         else passed++;
      end
   endtask

   task automatic test_lock_gap();
      pq[0].push_back({1'b0, 8'h10});
      pq[0].push_back({1'b1, 8'h11});
      pq[1].push_back({1'b1, 8'h66});
      run_traffic(40, 40, 600);
      check_traffic("lock_gap", 1'b0);
   endtask

   task automatic test_random();
      int len;
      for (int i = 0; i < NREQ; i++)
         for (int p = 0; p < 3; p++) begin
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++)
               pq[i].push_back({(b == len - 1), 8'($urandom_range(255))});
         end
      run_traffic(0, 30, 4000);
      check_traffic("random", 1'b0);
   endtask

   task automatic test_reset_mid_byte();
      int c;
      bit seen;
      req_valid[0] = 1'b1; req_data[7:0] = 8'h7E; req_last[0] = 1'b1;
      seen = 0;
      for (c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (tx_wr) seen = 1;
      end
      total++;
      if (!seen) $display("FAIL mid_issue: got no tx_wr, expected one");
      else passed++;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      repeat (5) @(posedge clk);
      #2 resetq = 1'b0;
      #1;
      total++;
      if (grant !== '0 || tx_wr !== 1'b0 || req_ready !== '0 || tx_data !== 8'h00)
         $display("FAIL mid_reset_outputs: got g=%b wr=%b rdy=%b d=%02h, expected zeros", grant, tx_wr, req_ready, tx_data);
      else passed++;
      total++;
      if (tx_busy !== 1'b1) $display("FAIL mid_busy: got busy=%b, expected 1", tx_busy);
      else passed++;
      req_valid[1] = 1'b1; req_data[15:8] = 8'hA5; req_last[1] = 1'b1;
      @(negedge clk) resetq = 1'b1;
      model_ptr = 0;
      seen = 0;
      for (c = 0; c < 3 * FRAME && !seen; c++) begin
         @(negedge clk);
         if (tx_wr) begin
            seen = 1;
            total++;
            if (tx_busy !== 1'b0) $display("FAIL mid_next_wr: got wr while busy=%b, expected 0", tx_busy);
            else passed++;
         end
      end
      total++;
      if (!seen) $display("FAIL mid_next: got no tx_wr, expected 0xA5 issue");
      else passed++;
      @(posedge clk); #1;
      req_valid = '0;
      repeat (FRAME + GEXTRA + 4) @(posedge clk);
      #1;
      total++;
      if (sent_q.size() < 2 || sent_q[sent_q.size()-2] !== 8'h7E || sent_q[sent_q.size()-1] !== 8'hA5)
         $display("FAIL mid_frames: got %0d frames, expected ... 0x7E 0xA5", sent_q.size());
      else passed++;
      total++;
      if (overruns != 0) $display("FAIL mid_overrun: got %0d, expected 0", overruns);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_lock_priority();
      test_round_robin();
      test_lock_gap();
      test_random();
      test_reset_mid_byte();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
